// File: rtl/ahb_mux_pkg.sv
// Shared types and encodings for the AHB slave-side multiplexer.
package ahb_mux_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Data-phase select: 0..15 are slave indices, DSEL_DEF is the internal default slave.
  localparam int unsigned     DSEL_W   = 5;
  localparam logic [DSEL_W-1:0] DSEL_DEF = 5'd16;

  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers, plus optional
// wait-state timeout override (enabled by KVIPS_AHB_MUX_TIMEOUT_EN).
module ahb_default_slave #(
  parameter int unsigned HRESP_W     = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               hready,
  input  logic [1:0]         htrans,
  input  logic               addr_unmapped,
  input  logic               dsel_slv,
  output logic               ds_hready_c,
  output logic [HRESP_W-1:0] ds_hresp_c,
  output logic               override_c,
  output logic               timeout_evt
);
  import ahb_mux_pkg::*;

  ds_state_e state_q, state_d;
  logic      accept_err_c;
  logic      timeout_hit_c;

  assign accept_err_c = hready && addr_unmapped && trans_active(htrans);

`ifdef KVIPS_AHB_MUX_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts consecutive slave wait states; the override cycles do not count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                        wait_cnt_q <= '0;
    else if (hready || state_q != DS_IDLE || !dsel_slv)  wait_cnt_q <= '0;
    else                                                 wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end

  assign timeout_hit_c = (state_q == DS_IDLE) && dsel_slv && !hready &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) timeout_evt <= 1'b0;
    else          timeout_evt <= timeout_hit_c;
  end
`else
  logic [16:0] unused_cfg;
  assign unused_cfg    = {dsel_slv, 16'(TIMEOUT_CYC)};
  assign timeout_hit_c = 1'b0;
  assign timeout_evt   = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ds_hready_c = 1'b1;
    ds_hresp_c  = HRESP_W'(HRESP_OKAY);
    case (state_q)
      DS_ERR1: begin
        ds_hready_c = 1'b0;
        ds_hresp_c  = HRESP_W'(HRESP_ERROR);
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp_c = HRESP_W'(HRESP_ERROR);
        state_d    = accept_err_c ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        if (timeout_hit_c || accept_err_c) state_d = DS_ERR1;
      end
    endcase
  end

  assign override_c = (state_q != DS_IDLE);

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB slave-side decoder and response multiplexer with internal default slave.
// Optional wait-state timeout: define KVIPS_AHB_MUX_TIMEOUT_EN.
module ahb_slave_mux #(
  parameter int unsigned               ADDR_W      = 32,
  parameter int unsigned               DATA_W      = 32,
  parameter int unsigned               NUM_SLV     = 4,
  parameter int unsigned               HRESP_W     = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = '0,
  parameter int unsigned               TIMEOUT_CYC = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [ADDR_W-1:0]           HADDR,
  input  logic [1:0]                  HTRANS,
  output logic                        HREADY,
  output logic [DATA_W-1:0]           HRDATA,
  output logic [HRESP_W-1:0]          HRESP,
  output logic [NUM_SLV-1:0]          S_HSEL,
  output logic                        S_HREADY,
  input  logic [NUM_SLV*DATA_W-1:0]   S_HRDATA,
  input  logic [NUM_SLV-1:0]          S_HREADYOUT,
  input  logic [NUM_SLV*HRESP_W-1:0]  S_HRESP,
  output logic                        TIMEOUT_EVT
);
  import ahb_mux_pkg::*;

  logic [DSEL_W-1:0]  dec_sel_c;
  logic [NUM_SLV-1:0] hsel_c;
  logic [DSEL_W-1:0]  dsel_q;
  logic               hready_c;
  logic [DATA_W-1:0]  hrdata_c;
  logic [HRESP_W-1:0] hresp_c;
  logic               ds_hready_c;
  logic [HRESP_W-1:0] ds_hresp_c;
  logic               ds_override_c;

  // Address decode; walking downwards lets the lowest matching index win.
  always_comb begin
    dec_sel_c = DSEL_DEF;
    hsel_c    = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_sel_c = DSEL_W'(i);
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign S_HSEL = hsel_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      dsel_q <= DSEL_DEF;
    else if (hready_c) dsel_q <= dec_sel_c;
  end

  ahb_default_slave #(
    .HRESP_W     (HRESP_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_default_slave (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .hready        (hready_c),
    .htrans        (HTRANS),
    .addr_unmapped (dec_sel_c == DSEL_DEF),
    .dsel_slv      (dsel_q != DSEL_DEF),
    .ds_hready_c   (ds_hready_c),
    .ds_hresp_c    (ds_hresp_c),
    .override_c    (ds_override_c),
    .timeout_evt   (TIMEOUT_EVT)
  );

  // Data-phase response mux; an active default-slave sequence overrides the slave.
  always_comb begin
    hready_c = ds_hready_c;
    hrdata_c = '0;
    hresp_c  = ds_hresp_c;
    if (!ds_override_c && dsel_q != DSEL_DEF) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (dsel_q == DSEL_W'(i)) begin
          hready_c = S_HREADYOUT[i];
          hrdata_c = S_HRDATA[i*DATA_W +: DATA_W];
          hresp_c  = S_HRESP[i*HRESP_W +: HRESP_W];
        end
      end
    end
  end

  assign HREADY   = hready_c;
  assign S_HREADY = hready_c;
  assign HRDATA   = hrdata_c;
  assign HRESP    = hresp_c;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Randomized bench for ahb_slave_mux against a transaction-level reference model.
module tb_ahb_slave_mux;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned RW = 2;
  localparam int unsigned TO = 8;

  localparam logic [AW-1:0] B0 = 32'h0000_0000, M0 = 32'hF000_0000;
  localparam logic [AW-1:0] B1 = 32'h1000_0000, M1 = 32'hF0F0_0000;
  localparam logic [AW-1:0] B2 = 32'h1000_0000, M2 = 32'hF000_0000;

`ifdef KVIPS_AHB_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic [DW-1:0]     HRDATA;
  logic [RW-1:0]     HRESP;
  logic [NS-1:0]     S_HSEL;
  logic              S_HREADY;
  logic [NS*DW-1:0]  S_HRDATA;
  logic [NS-1:0]     S_HREADYOUT;
  logic [NS*RW-1:0]  S_HRESP;
  logic              TIMEOUT_EVT;

  ahb_slave_mux #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .HRESP_W(RW),
    .SLV_BASE({B2, B1, B0}), .SLV_MASK({M2, M1, M0}), .TIMEOUT_CYC(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
    .S_HSEL(S_HSEL), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .TIMEOUT_EVT(TIMEOUT_EVT)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the data phase, how many error cycles remain,
  // how many waits the current slave has inserted.
  logic [AW-1:0] base_a [NS] = '{B0, B1, B2};
  logic [AW-1:0] mask_a [NS] = '{M0, M1, M2};
  int  m_tgt, m_err, m_wait;
  bit  m_to;
  bit            e_ready, e_evt;
  logic [DW-1:0] e_rdata;
  logic [RW-1:0] e_resp;

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == base_a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_tgt = -1; m_err = 0; m_wait = 0; m_to = 1'b0;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [1:0] t, input logic [NS-1:0] rdy,
                       input logic [NS*DW-1:0] d, input logic [NS*RW-1:0] r);
    HADDR = a; HTRANS = t; S_HREADYOUT = rdy; S_HRDATA = d; S_HRESP = r;
  endtask

  task automatic sample(input string tag);
    int t;
    logic [NS-1:0] e_hsel;
    @(negedge HCLK);
    e_evt = 1'b0; e_rdata = '0;
    if (m_err == 2) begin
      e_ready = 1'b0; e_resp = 2'b01; e_evt = m_to;
    end else if (m_err == 1) begin
      e_ready = 1'b1; e_resp = 2'b01;
    end else if (m_tgt < 0) begin
      e_ready = 1'b1; e_resp = 2'b00;
    end else begin
      e_ready = S_HREADYOUT[m_tgt];
      e_rdata = S_HRDATA[m_tgt*DW +: DW];
      e_resp  = S_HRESP[m_tgt*RW +: RW];
    end
    t = decode(HADDR);
    e_hsel = '0;
    if (t >= 0) e_hsel[t] = 1'b1;
    check({tag, ".hsel"},     64'(S_HSEL),      64'(e_hsel));
    check({tag, ".hready"},   64'(HREADY),      64'(e_ready));
    check({tag, ".s_hready"}, 64'(S_HREADY),    64'(e_ready));
    check({tag, ".hrdata"},   64'(HRDATA),      64'(e_rdata));
    check({tag, ".hresp"},    64'(HRESP),       64'(e_resp));
    check({tag, ".evt"},      64'(TIMEOUT_EVT), 64'(e_evt));
  endtask

  task automatic advance();
    int nx_tgt, nx_err, nx_wait, t;
    bit nx_to;
    nx_tgt = m_tgt; nx_err = m_err; nx_wait = m_wait; nx_to = 1'b0;
    if (m_err == 2) begin
      nx_err = 1;
    end else if (e_ready) begin
      t = decode(HADDR);
      nx_tgt = t; nx_wait = 0;
      nx_err = (t < 0 && HTRANS[1]) ? 2 : 0;
    end else begin
      nx_wait = m_wait + 1;
      if (TO_EN && nx_wait == int'(TO)) begin
        nx_err = 2; nx_to = 1'b1; nx_wait = 0;
      end
    end
    @(posedge HCLK);
    #1;
    if (!HRESETn) model_reset();
    else begin
      m_tgt = nx_tgt; m_err = nx_err; m_wait = nx_wait; m_to = nx_to;
    end
  endtask

  task automatic cycle(input string tag);
    sample(tag);
    advance();
  endtask

  // Asynchronous reset from the middle of the low clock phase.
  task automatic pulse_reset();
    #2 HRESETn = 1'b0;
    #1;
    check("async.hready", 64'(HREADY), 64'd1);
    check("async.hresp",  64'(HRESP),  64'd0);
    check("async.hrdata", 64'(HRDATA), 64'd0);
    check("async.evt",    64'(TIMEOUT_EVT), 64'd0);
    model_reset();
    @(posedge HCLK);
    #1;
    sample("rst_hold");
    HRESETn = 1'b1;
    advance();
  endtask

  localparam logic [NS*DW-1:0] DV = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};

  initial begin
    int n_lo, n_pulse, first;
    logic [AW-1:0] a;

    model_reset();
    drive(32'h0, 2'b00, '1, '0, '0);
    sample("reset");
    HRESETn = 1'b1;
    advance();

    // Mapped zero-wait read through the overlapping slave 1/slave 2 region.
    drive(32'h1000_0004, 2'b10, '1, {32'h0, 32'hCAFE_F00D, 32'h0}, '0);
    sample("rd_addr");
    check("rd.hsel", 64'(S_HSEL), 64'(3'b010));
    advance();
    drive(32'h0, 2'b00, '1, {32'h0, 32'hCAFE_F00D, 32'h0}, '0);
    sample("rd_data");
    check("rd.hrdata", 64'(HRDATA), 64'h0000_0000_CAFE_F00D);
    check("rd.hready", 64'(HREADY), 64'd1);
    advance();

    // Unmapped NONSEQ write: two-cycle ERROR then OKAY.
    drive(32'h2000_0000, 2'b10, '1, DV, '0);
    sample("err_addr");
    check("err.hsel", 64'(S_HSEL), 64'd0);
    advance();
    drive(32'h0, 2'b00, '1, DV, '0);
    sample("err1");
    check("err1.hready", 64'(HREADY), 64'd0);
    check("err1.hresp",  64'(HRESP),  64'd1);
    advance();
    sample("err2");
    check("err2.hready", 64'(HREADY), 64'd1);
    check("err2.hresp",  64'(HRESP),  64'd1);
    advance();
    sample("err_done");
    check("done.hresp", 64'(HRESP), 64'd0);
    advance();

    // Slave 0 inserts 3 waits while the next address targets slave 1.
    drive(32'h0000_0100, 2'b10, '1, DV, '0);
    cycle("b2b_a0");
    for (int k = 0; k < 3; k++) begin
      drive(32'h1000_0008, 2'b10, 3'b110, DV, '0);
      sample("b2b_wait");
      check("b2b.wait_data", 64'(HRDATA), 64'hAAAA_0000);
      advance();
    end
    drive(32'h1000_0008, 2'b10, 3'b111, DV, '0);
    sample("b2b_last");
    check("b2b.last_data", 64'(HRDATA), 64'hAAAA_0000);
    advance();
    drive(32'h0, 2'b00, 3'b111, DV, '0);
    sample("b2b_s1");
    check("b2b.s1_data", 64'(HRDATA), 64'hBBBB_1111);
    advance();

    // Slave 0 stalls indefinitely; the bus idles on an unmapped address.
    drive(32'h0000_0100, 2'b10, '1, DV, '0);
    cycle("to_addr");
    n_lo = 0; n_pulse = 0; first = -1;
    for (int k = 0; k < 100; k++) begin
      drive(32'h2000_0000, 2'b00, 3'b110, DV, '0);
      sample("to_hold");
      if (!HREADY) n_lo++;
      if (TIMEOUT_EVT) begin
        n_pulse++;
        if (first < 0) first = k;
      end
      advance();
    end
`ifdef KVIPS_AHB_MUX_TIMEOUT_EN
    check("to.lo_cycles", 64'(n_lo),    64'd9);
    check("to.pulses",    64'(n_pulse), 64'd1);
    check("to.first",     64'(first),   64'd8);
`else
    check("to.lo_cycles", 64'(n_lo),    64'd100);
    check("to.pulses",    64'(n_pulse), 64'd0);
`endif
    if (!TO_EN) begin
      // Free the stalled slave so the bench can continue.
      drive(32'h0, 2'b00, '1, DV, '0);
      cycle("to_release");
    end

    // Reset during DS_ERR1, then an IDLE transfer.
    drive(32'h3000_0000, 2'b11, '1, DV, '0);
    cycle("rst_addr");
    drive(32'h0, 2'b00, '1, DV, '0);
    sample("rst_err1");
    check("rst.err1_hready", 64'(HREADY), 64'd0);
    pulse_reset();
    drive(32'h0, 2'b00, '1, DV, '0);
    sample("rst_after");
    check("rst.after_hresp",  64'(HRESP),  64'd0);
    check("rst.after_hready", 64'(HREADY), 64'd1);
    advance();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h0000_0000 | ($urandom & 32'h0FFF_FFFF);
        1:       a = 32'h1000_0000 | ($urandom & 32'h000F_FFFF);
        2:       a = 32'h1010_0000 | ($urandom & 32'h000F_FFFF);
        3:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
        default: a = 32'($urandom);
      endcase
      drive(a, 2'($urandom_range(0, 3)),
            {NS{1'b0}} | {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)},
            {32'($urandom), 32'($urandom), 32'($urandom)}, 6'($urandom));
      sample("rand");
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mux.md
AHB_SLAVE_MUX -- requirements
Module: ahb_slave_mux

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter NUM_SLV, 4, slave port count (1..16).
REQ-004 Parameter HRESP_W, 2, response width (1 = AHB-Lite, 2 = AHB Full).
REQ-005 Parameter SLV_BASE, all zero, packed NUM_SLV*ADDR_W base addresses.
REQ-006 Parameter SLV_MASK, all zero, packed NUM_SLV*ADDR_W masks; slave i matches when (HADDR & mask_i) == base_i.
REQ-007 Parameter TIMEOUT_CYC, 256, maximum consecutive wait cycles before forced ERROR (16 bit).
REQ-008 One clock; reset is asynchronous and active-low: HCLK input 1, HRESETn input 1.
REQ-009 Master-side ports: HADDR input ADDR_W; HTRANS input 2; HREADY output 1 (global ready); HRDATA output DATA_W; HRESP output HRESP_W.
REQ-010 Slave-side ports: S_HSEL output NUM_SLV; S_HREADY output 1 (copy of HREADY); S_HRDATA input NUM_SLV*DATA_W; S_HREADYOUT input NUM_SLV; S_HRESP input NUM_SLV*HRESP_W.
REQ-011 Status port: TIMEOUT_EVT output 1, single-cycle pulse on a forced timeout.

Function
REQ-012 S_HSEL is combinational from HADDR only; on overlapping matches, only the lowest index is set; on no match, all bits are 0 and the internal default slave is selected.
REQ-013 A data-phase select register (dsel: slave index or DEF) loads the decoded target on every HCLK edge where HREADY=1, and holds while HREADY=0.
REQ-014 With dsel=i: HREADY = S_HREADYOUT[i], HRDATA = slice i of S_HRDATA, HRESP = slice i of S_HRESP, all combinational (zero added latency).
REQ-015 The default slave has states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-016 An unmapped address accepted with HTRANS NONSEQ (2'b10) or SEQ (2'b11) moves the default slave to DS_ERR1: HREADY=0, HRESP=ERROR.
REQ-017 The cycle after DS_ERR1 is DS_ERR2 (HREADY=1, HRESP=ERROR), followed by DS_IDLE, or by DS_ERR1 again if another active unmapped transfer is accepted in DS_ERR2.
REQ-018 An unmapped IDLE/BUSY transfer gets a zero-wait OKAY response with HRDATA=0.
REQ-019 A wait counter increments each cycle with dsel=slave and HREADY=0, and clears whenever HREADY=1 or dsel changes.
REQ-020 HRESP ERROR encoding is 1 in the LSB, upper bits 0; OKAY is all zero.
REQ-021 During any transfer where HRESP is not OKAY, the mux forwards the value unchanged.

Reset
REQ-022 While HRESETn=0: dsel=DEF, default slave in DS_IDLE, wait counter=0, HREADY=1, HRESP=OKAY, HRDATA=0, TIMEOUT_EVT=0.
REQ-023 Reset assertion mid-wait or mid-ERROR aborts immediately to the REQ-022 state, with no residual ERROR cycle after release.

Configuration
REQ-024 Macro KVIPS_AHB_MUX_TIMEOUT_EN defined: when the wait counter reaches TIMEOUT_CYC, the mux overrides the slave with the two-cycle ERROR sequence (DS_ERR1, DS_ERR2), pulses TIMEOUT_EVT in the DS_ERR1 cycle, ignores S_HREADYOUT/S_HRESP of that slave for those 2 cycles, and sets dsel per REQ-013 at DS_ERR2.
REQ-025 Macro KVIPS_AHB_MUX_TIMEOUT_EN undefined: the wait counter and override logic are absent, TIMEOUT_EVT is tied 0, and waits are unbounded.

Structure
REQ-026 Package ahb_mux_pkg holds: ds_state_e, HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HRESP encodings (OKAY, ERROR), and the DEF select constant.
REQ-027 The default-slave FSM and timeout override live in sub-module ahb_default_slave; decode, dsel and the muxes live in the top level.

Verification
REQ-028 NUM_SLV=2, base 0x0000_0000 and 0x1000_0000, mask 0xF000_0000; NONSEQ read of 0x1000_0004 with slave 1 returning 0xCAFE_F00D at zero wait -> S_HSEL=2'b10 in the address phase; HRDATA=0xCAFE_F00D, HREADY=1, HRESP=OKAY in the next cycle.
REQ-029 Same map; NONSEQ write to 0x2000_0000 -> S_HSEL=0; next cycle HREADY=0, HRESP=ERROR; following cycle HREADY=1, HRESP=ERROR; then OKAY.
REQ-030 Back-to-back transfers: slave 0 inserts 3 wait states while the next address targets slave 1 -> dsel holds 0 for 4 cycles, then switches; there is no data-phase crossover.
REQ-031 With KVIPS_AHB_MUX_TIMEOUT_EN defined and TIMEOUT_CYC=8, slave 0 holds S_HREADYOUT=0 -> TIMEOUT_EVT pulses once after 8 wait cycles, followed by the two-cycle ERROR; without the macro, HREADY stays 0 for 100 cycles.
REQ-032 HRESETn is asserted during DS_ERR1 -> HREADY=1 and HRESP=OKAY asynchronously; after release, an IDLE transfer returns OKAY.
